// File: rtl/pattern_pkg.sv
// Shared constants, state encoding and helpers for the VGA pattern playlist logic.
package pattern_pkg;

  localparam int unsigned NUM_PATTERNS = 3;
  localparam int unsigned SEL_W        = 2;
  localparam int unsigned FC_W         = 10;
  localparam int unsigned BC_W         = 8;
  localparam int unsigned STEP_W       = 3;

  localparam logic [SEL_W-1:0] PATTERN_CHECKERBOARD = 2'd0;
  localparam logic [SEL_W-1:0] PATTERN_RADIENT      = 2'd1;
  localparam logic [SEL_W-1:0] PATTERN_SPIRAL       = 2'd2;

  localparam int unsigned DWELL0_DEFAULT       = 240;
  localparam int unsigned DWELL1_DEFAULT       = 480;
  localparam int unsigned DWELL2_DEFAULT       = 360;
  localparam int unsigned BLANK_FRAMES_DEFAULT = 8;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_BLANK = 1'b1
  } sched_state_e;

  // One-hot generator vector for a pattern index.
  function automatic logic [NUM_PATTERNS-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    return NUM_PATTERNS'(1) << sel;
  endfunction

endpackage

// File: rtl/frame_tick_detect.sv
// Frame tick from the rising edge of active-low vsync; one pixel-clock wide.
module frame_tick_detect (
  input  logic clk,
  input  logic rst,
  input  logic vsync_i,
  output logic tick_c_o
);

  logic vsync_q;

  // Resets high so no spurious tick follows reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vsync_q <= 1'b1;
    else     vsync_q <= vsync_i;
  end

  assign tick_c_o = vsync_i & ~vsync_q;

endmodule

// File: rtl/pattern_scheduler.sv
// Frame-synchronous playlist controller: dwell counting, blanking between patterns,
// per-frame animation strobes and generator reset pulses.
module pattern_scheduler
  import pattern_pkg::*;
#(
  parameter int unsigned DWELL0       = DWELL0_DEFAULT,
  parameter int unsigned DWELL1       = DWELL1_DEFAULT,
  parameter int unsigned DWELL2       = DWELL2_DEFAULT,
  parameter int unsigned BLANK_FRAMES = BLANK_FRAMES_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    vsync_i,
  input  logic                    btn_next_i,
  input  logic                    btn_prev_i,
  input  logic                    btn_pause_i,
  input  logic                    btn_speed_i,
  output logic [SEL_W-1:0]        pattern_select_o,
  output logic [NUM_PATTERNS-1:0] anim_strobe_o,
  output logic [NUM_PATTERNS-1:0] gen_rst_o,
  output logic                    blank_o,
  output logic                    paused_o,
  output logic [STEP_W-1:0]       step_size_o,
  output logic [FC_W-1:0]         frame_count_o
);

  sched_state_e            state_q, state_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [FC_W-1:0]         fc_q, fc_d;
  logic [BC_W-1:0]         bc_q, bc_d;
  logic                    blank_q, blank_d;
  logic                    paused_q, paused_d;
  logic [STEP_W-1:0]       step_q, step_d;
  logic [NUM_PATTERNS-1:0] strobe_q, strobe_d;
  logic [NUM_PATTERNS-1:0] grst_q, grst_d;

  logic             tick;
  logic [FC_W-1:0]  dwell_last;
  logic [SEL_W-1:0] sel_inc;
  logic [SEL_W-1:0] sel_dec;

  frame_tick_detect u_tick (
    .clk      (clk),
    .rst      (rst),
    .vsync_i  (vsync_i),
    .tick_c_o (tick)
  );

  // Last frame index of the current pattern's dwell.
  always_comb begin
    dwell_last = FC_W'(DWELL0 - 1);
    case (sel_q)
      PATTERN_CHECKERBOARD: dwell_last = FC_W'(DWELL0 - 1);
      PATTERN_RADIENT:      dwell_last = FC_W'(DWELL1 - 1);
      PATTERN_SPIRAL:       dwell_last = FC_W'(DWELL2 - 1);
      default:              dwell_last = FC_W'(DWELL0 - 1);
    endcase
  end

  assign sel_inc = (sel_q == SEL_W'(NUM_PATTERNS - 1)) ? '0 : sel_q + SEL_W'(1);
  assign sel_dec = (sel_q == '0) ? SEL_W'(NUM_PATTERNS - 1) : sel_q - SEL_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      sel_q    <= PATTERN_CHECKERBOARD;
      fc_q     <= '0;
      bc_q     <= '0;
      blank_q  <= 1'b0;
      paused_q <= 1'b0;
      step_q   <= STEP_W'(1);
      strobe_q <= '0;
      grst_q   <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      fc_q     <= fc_d;
      bc_q     <= bc_d;
      blank_q  <= blank_d;
      paused_q <= paused_d;
      step_q   <= step_d;
      strobe_q <= strobe_d;
      grst_q   <= grst_d;
    end
  end

  // Buttons take priority over a coincident frame tick; next+prev together cancel.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    fc_d     = fc_q;
    bc_d     = bc_q;
    blank_d  = blank_q;
    paused_d = paused_q ^ btn_pause_i;
    step_d   = step_q;
    strobe_d = '0;
    grst_d   = '0;

    if (btn_speed_i) begin
      step_d = (step_q == STEP_W'(7)) ? STEP_W'(1) : step_q + STEP_W'(1);
    end

    if (btn_next_i ^ btn_prev_i) begin
      sel_d   = btn_next_i ? sel_inc : sel_dec;
      state_d = ST_BLANK;
      blank_d = 1'b1;
      fc_d    = '0;
      bc_d    = '0;
      grst_d  = sel_onehot(sel_d);
    end else if (tick) begin
      if (state_q == ST_BLANK) begin
        bc_d = bc_q + BC_W'(1);
        if (bc_q == BC_W'(BLANK_FRAMES - 1)) begin
          state_d = ST_RUN;
          blank_d = 1'b0;
          fc_d    = '0;
        end
      end else if (!paused_q) begin
        if (fc_q == dwell_last) begin
          sel_d   = sel_inc;
          state_d = ST_BLANK;
          blank_d = 1'b1;
          fc_d    = '0;
          bc_d    = '0;
          grst_d  = sel_onehot(sel_inc);
        end else begin
          fc_d     = fc_q + FC_W'(1);
          strobe_d = sel_onehot(sel_q);
        end
      end
    end
  end

  assign pattern_select_o = sel_q;
  assign anim_strobe_o    = strobe_q;
  assign gen_rst_o        = grst_q;
  assign blank_o          = blank_q;
  assign paused_o         = paused_q;
  assign step_size_o      = step_q;
  assign frame_count_o    = fc_q;

endmodule

// File: doc/pattern_scheduler.md
# pattern_scheduler

Frame-synchronous playlist controller for the VGA pattern generators. It detects frame boundaries from vsync and selects which generator drives the display. It issues each generator's per-frame animation strobe and reset pulse, and inserts a black blanking interval between patterns. User controls (next, previous, pause, speed) arrive as single-cycle pulses. The block sits between the debounced-input logic and the pattern generator/mux datapath.

## Interface
- NUM_PATTERNS, 3, number of generators; pattern indices 0..NUM_PATTERNS-1
- DWELL0, 240, frames pattern 0 is shown
- DWELL1, 480, frames pattern 1 is shown
- DWELL2, 360, frames pattern 2 is shown
- BLANK_FRAMES, 8, black frames inserted at each switch; legal range 1..255
- DWELLn legal range 1..1023

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset, asynchronous, active-high
- vsync  in  1  VGA vsync, active low; its rising edge is the frame tick
- btn_next  in  1  one-cycle pulse; advance to next pattern
- btn_prev  in  1  one-cycle pulse; go to previous pattern
- btn_pause  in  1  one-cycle pulse; toggle pause
- btn_speed  in  1  one-cycle pulse; cycle step_size
- pattern_select  out  2  active generator index for the rgb mux
- anim_strobe  out  NUM_PATTERNS  one-hot next_frame strobe to the selected generator
- gen_rst  out  NUM_PATTERNS  one-hot, one-cycle reset pulse to the generator being entered
- blank  out  1  force rgb to 0
- paused  out  1  pause state
- step_size  out  3  animation step, 1..7
- frame_count  out  10  frames elapsed in the current dwell

## Operation
- Frame tick: vsync sampled high while registered vsync_q is low. vsync_q resets to 1, so there is no tick immediately after reset.
- States:
  - RUN: pattern visible, blank=0.
  - BLANK: blank=1, blank_cnt counts frame ticks.
- RUN, frame tick:
  - If !paused and frame_count == DWELL[sel]-1: sel <= (sel+1) mod NUM_PATTERNS, frame_count <= 0, blank_cnt <= 0, state <= BLANK, gen_rst[new sel] pulses.
  - Else if !paused: frame_count++ and anim_strobe[sel] pulses.
  - Paused: no count, no strobe.
- BLANK, frame tick:
  - blank_cnt++ regardless of pause.
  - If blank_cnt == BLANK_FRAMES-1: state <= RUN, frame_count <= 0.
  - No anim_strobe in BLANK.
- btn_next: in any state, sel <= sel+1 mod N, enter BLANK with blank_cnt=0, frame_count=0, gen_rst[new sel] pulses.
- btn_prev: same, with sel <= sel-1 mod N; 0 wraps to NUM_PATTERNS-1.
- btn_next and btn_prev in the same cycle: both ignored.
- A button coinciding with a frame tick: the button wins, and the tick's count/strobe is discarded.
- btn_pause toggles paused in any state.
- Pause does not block btn_next/btn_prev. The blank interval still completes, then the block sits in RUN paused.
- btn_speed: step_size <= (step_size==7) ? 1 : step_size+1.
- Width rules:
  - Dwell comparisons are 10-bit unsigned.
  - blank_cnt is 8-bit.
  - sel never leaves 0..NUM_PATTERNS-1.

## Timing
- All outputs are registered.
- anim_strobe and gen_rst are high for exactly one cycle, in the cycle after the edge that sampled the frame tick or button.
- pattern_select, blank, frame_count and step_size update on that same edge. A new pattern is therefore selected and blanked in the same cycle its gen_rst is high.
- anim_strobe and gen_rst are never both high on the same bit.
- Reset values: pattern_select=0, state=RUN, frame_count=0, blank=0, paused=0, step_size=1, anim_strobe=0, gen_rst=0, blank_cnt=0, vsync_q=1.
- Reset mid-blank or mid-dwell returns the block to pattern 0 in RUN immediately. No gen_rst is issued, because rst itself resets the generators.

## Structure
- Shared package pattern_pkg holds:
  - PATTERN_CHECKERBOARD=0, PATTERN_RADIENT=1, PATTERN_SPIRAL=2
  - NUM_PATTERNS
  - scheduler state encoding: RUN, BLANK
  - default dwell constants
- One sub-module, frame_tick_detect: the vsync edge detector (registered vsync_q, outputs tick). It is reusable by other frame-rate logic.
- Dwell lookup is a combinational case on sel inside pattern_scheduler.

## Test plan
- Reset, then 240 vsync pulses with DWELL0=240 -> 239 anim_strobe[0] pulses, then gen_rst=3'b010, pattern_select=1, blank=1 for 8 frame ticks, then blank=0 and frame_count=0.
- Run through pattern 2's 360 frames -> pattern_select wraps to 0, gen_rst=3'b001.
- btn_pause at frame 100 of pattern 0, then 500 ticks -> frame_count holds 100, no anim_strobe, pattern_select stays 0. A second btn_pause resumes counting from 101.
- btn_prev at pattern 0 -> pattern_select=2, gen_rst=3'b100, blank=1. btn_next and btn_prev in the same cycle -> no change.
- btn_next on the same cycle as a frame tick during BLANK -> sel advances again and blank_cnt restarts at 0 (8 more black frames).
- Seven btn_speed pulses from reset -> step_size goes 2,3,4,5,6,7,1. Asserting rst mid-blank -> all outputs return to reset values asynchronously.
